demux1to2_b32_buf: RTL and testbench
====================================

Name: demux1to2_b32_buf

Overview:
- Buffered 1-to-2 demultiplexer: the write-side counterpart of the 2:1 datapath select mux.
- Takes one valid/ready stream of data words plus a per-word select bit. Routes each accepted word into one of two independent output FIFOs.
- Each output drains under its own valid/ready handshake.
- Used where one pipeline result stream must be steered to two consumers, e.g. data memory vs. MMIO store path, without stalling the producer while the other consumer is busy.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output FIFO. Power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous reset, active-high.
- s  input  1  destination select for the word on I: 0 routes to output 0, 1 routes to output 1.
- i_valid  input  1  upstream word valid.
- i_ready  output  1  block can accept the word on I for the port selected by s.
- I  input  WIDTH  upstream data word.
- o0_valid  output  1  output 0 FIFO non-empty.
- o0_ready  input  1  consumer 0 accepts the head word.
- o0  output  WIDTH  output 0 head word.
- o1_valid  output  1  output 1 FIFO non-empty.
- o1_ready  input  1  consumer 1 accepts the head word.
- o1  output  WIDTH  output 1 head word.
- cnt0  output  $clog2(DEPTH+1)  occupancy of output 0 FIFO.
- cnt1  output  $clog2(DEPTH+1)  occupancy of output 1 FIFO.

Behaviour:
- Clocking and reset: single clock domain. Synchronous, active-high reset.
- Reset values, on the first rising edge with rst=1:
  - cnt0, cnt1, o0_valid, o1_valid = 0.
  - All read/write pointers = 0. All FIFO storage = 0, so o0 and o1 = 0.
  - i_ready = 1 one cycle later (both FIFOs empty).
- Reset mid-operation: all buffered words are discarded and not delivered. The upstream handshake in the reset cycle is ignored.
- i_ready is combinational: (s==0) ? (cnt0!=DEPTH) : (cnt1!=DEPTH).
  - Depends on registered count and s only, never on o*_ready. No full-FIFO pass-through.
- Accept:
  - Happens on a clock edge where i_valid & i_ready & !rst.
  - The word I is written at the selected FIFO's write pointer, which then increments mod DEPTH.
  - s is sampled only at acceptance and may change freely while i_valid is low.
  - While i_valid=1 and the word is not yet accepted, upstream holds I and s stable. This is an upstream obligation; the block does not check it.
- Output side, per port k:
  - ok_valid = (cntk != 0).
  - ok = storage[rd_ptr_k]. The value is meaningful only while ok_valid=1.
  - Pop on an edge where ok_valid & ok_ready: rd_ptr_k increments mod DEPTH.
- Counts, per port per cycle:
  - cntk += push_k − pop_k.
  - Simultaneous push and pop on the same port leaves cntk unchanged; both pointers advance.
  - A push to one port and a pop from the other in the same cycle are independent.
- Latency: an accepted word appears on ok with ok_valid=1 in the cycle after acceptance. There is no combinational bypass from I to ok.
- Ordering: strict FIFO order per port. No ordering guarantee between ports.
- Full:
  - When cntk==DEPTH and s selects k, i_ready=0, even if ok_ready=1 in the same cycle.
  - i_ready rises the cycle after the pop.
  - If s selects the non-full port, i_ready=1 even when the other port is full; there is no head-of-line blocking on the select.
- Empty: ok_ready while ok_valid=0 has no effect. Pointers and counts never underflow.
- Wrap-around: pointers wrap from DEPTH−1 to 0 with no bubble.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then release → cnt0=cnt1=0, o0_valid=o1_valid=0, o0=o1=0, i_ready=1.
2. Routing and latency: o0_ready=o1_ready=1; send 0xA5A5_0001 (s=0), then 0x5A5A_0002 (s=1) on consecutive cycles → o0=0xA5A5_0001 valid 1 cycle after its accept; o1=0x5A5A_0002 valid 1 cycle later; each valid for exactly 1 cycle.
3. Full/back-pressure: o0_ready=0; send 3 words s=0 (0x10, 0x11, 0x12) → first two accepted, cnt0=2, i_ready=0 holding 0x12. Send a word with s=1 meanwhile → accepted. Raise o0_ready → 0x10, then 0x11, then 0x12 delivered in order; i_ready rises the cycle after the first pop.
4. Simultaneous push/pop plus wrap: cnt0=1, o0_ready=1, continuous s=0 stream 0x20..0x27 → cnt0 stays 1, outputs 0x20..0x27 in order, pointers wrap 4 times with no bubble.
5. Reset mid-operation: fill both FIFOs (cnt0=cnt1=2); assert rst 1 cycle with i_valid=1 → next cycle cnt0=cnt1=0, both valids 0, the word offered during reset is not delivered.
6. Randomized cross-check: 1000 cycles with random i_valid, s, o0_ready, o1_ready against a scoreboard → no loss, duplication, or reordering per port; cntk never exceeds DEPTH.

Source files
------------

// File: rtl/demux1to2_b32_buf.sv
// Buffered 1-to-2 demultiplexer.
// One valid/ready input stream is steered word by word, using the select bit s,
// into one of two independent output FIFOs. Each FIFO drains under its own
// valid/ready handshake, so a stalled consumer never blocks the other port.
//
// Input acceptance depends only on the registered occupancy of the selected
// FIFO. The output-side ready signals are never consulted, so there is no
// combinational path from o*_ready to i_ready. An accepted word becomes
// visible on its output in the following cycle; there is no I-to-o bypass.
module demux1to2_b32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [WIDTH-1:0]           I,
    output logic                       o0_valid,
    input  logic                       o0_ready,
    output logic [WIDTH-1:0]           o0,
    output logic                       o1_valid,
    input  logic                       o1_ready,
    output logic [WIDTH-1:0]           o1,
    output logic [$clog2(DEPTH+1)-1:0] cnt0,
    output logic [$clog2(DEPTH+1)-1:0] cnt1
);

    // Count width holds 0..DEPTH inclusive. The pointer width indexes
    // 0..DEPTH-1. Because DEPTH is a power of two, pointer overflow is the
    // mod-DEPTH wrap with no extra compare.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // Per-port views of the two FIFOs, gathered so the generate loop can build
    // both ports from a single description.
    logic [1:0]            not_full;
    logic [1:0]            has_data;
    logic [1:0]            out_ready;
    logic [1:0][CW-1:0]    occupancy;
    logic [1:0][WIDTH-1:0] head_word;

    assign out_ready = {o1_ready, o0_ready};

    // Acceptance is a function of the select and the selected FIFO's count only.
    assign i_ready = s ? not_full[1] : not_full[0];

    assign o0_valid = has_data[0];
    assign o1_valid = has_data[1];
    assign o0       = head_word[0];
    assign o1       = head_word[1];
    assign cnt0     = occupancy[0];
    assign cnt1     = occupancy[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [WIDTH-1:0] mem_reg [DEPTH];
            logic [PW-1:0]    wr_ptr_reg;
            logic [PW-1:0]    wr_ptr_next;
            logic [PW-1:0]    rd_ptr_reg;
            logic [PW-1:0]    rd_ptr_next;
            logic [CW-1:0]    cnt_reg;
            logic [CW-1:0]    cnt_next;
            logic             sel_hit;
            logic             push;
            logic             pop;

            // This port is the destination of the word currently on I.
            assign sel_hit = (s == 1'(gi));

            assign not_full[gi]  = (cnt_reg != CW'(DEPTH));
            assign has_data[gi]  = (cnt_reg != '0);
            assign occupancy[gi] = cnt_reg;
            assign head_word[gi] = mem_reg[rd_ptr_reg];

            // A push needs this port selected and not full. A pop needs a
            // buffered word, so a ready consumer on an empty FIFO does nothing
            // and the count cannot underflow.
            assign push = i_valid & sel_hit & not_full[gi];
            assign pop  = has_data[gi] & out_ready[gi];

            // Next pointer and occupancy. A push and a pop in the same cycle
            // move both pointers but leave the count unchanged.
            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                cnt_next    = cnt_reg;
                if (push) begin
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                end
                case ({push, pop})
                    2'b10:   cnt_next = cnt_reg + 1'b1;
                    2'b01:   cnt_next = cnt_reg - 1'b1;
                    default: cnt_next = cnt_reg;
                endcase
            end

            // Pointer and count registers. Reset drops every buffered word and
            // takes priority over any handshake seen in the same cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    cnt_reg    <= cnt_next;
                end
            end

            // Storage. It is cleared on reset so that the head outputs read
            // zero afterwards. Because of that clear, the array becomes
            // registers rather than block RAM; at this depth that is cheap.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        mem_reg[k] <= '0;
                    end
                end else if (push) begin
                    mem_reg[wr_ptr_reg] <= I;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_demux1to2_b32_buf.sv
// Directed and randomized checks for the buffered 1-to-2 demultiplexer.
module tb_demux1to2_b32_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             s;
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] I;
    logic             o0_valid;
    logic             o0_ready;
    logic [WIDTH-1:0] o0;
    logic             o1_valid;
    logic             o1_ready;
    logic [WIDTH-1:0] o1;
    logic [CW-1:0]    cnt0;
    logic [CW-1:0]    cnt1;

    int checks = 0;
    int errors = 0;

    demux1to2_b32_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (s),
        .i_valid  (i_valid),
        .i_ready  (i_ready),
        .I        (I),
        .o0_valid (o0_valid),
        .o0_ready (o0_ready),
        .o0       (o0),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .o1       (o1)   ,
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the edge, where registered
    // outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    initial begin
        rst = 1'b1; s = 1'b0; i_valid = 1'b0; I = '0;
        o0_ready = 1'b0; o1_ready = 1'b0;

        // 1. Reset then idle
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_o0_valid", o0_valid, 0);
        check("rst_o1_valid", o1_valid, 0);
        check("rst_o0", o0, 0);
        check("rst_o1", o1, 0);
        check("rst_i_ready", i_ready, 1);
        $display("reset released");

        // 2. Routing and latency
        o0_ready = 1'b1; o1_ready = 1'b1;
        i_valid = 1'b1; s = 1'b0; I = 32'hA5A5_0001;
        #1 check("rt_i_ready", i_ready, 1);
        tick();
        $display("push s=0 %h", 32'hA5A5_0001);
        check("rt_o0_valid", o0_valid, 1);
        check("rt_o0", o0, 32'hA5A5_0001);
        check("rt_o1_idle", o1_valid, 0);
        s = 1'b1; I = 32'h5A5A_0002;
        tick();
        $display("push s=1 %h", 32'h5A5A_0002);
        check("rt_o0_one_cycle", o0_valid, 0);
        check("rt_o1_valid", o1_valid, 1);
        check("rt_o1", o1, 32'h5A5A_0002);
        i_valid = 1'b0;
        tick();
        check("rt_o1_one_cycle", o1_valid, 0);
        check("rt_cnt0_empty", cnt0, 0);
        check("rt_cnt1_empty", cnt1, 0);

        // 3. Full and back-pressure
        o0_ready = 1'b0; o1_ready = 1'b0;
        i_valid = 1'b1; s = 1'b0; I = 32'h10;
        tick(); $display("push s=0 10");
        check("bp_cnt0_1", cnt0, 1);
        I = 32'h11;
        tick(); $display("push s=0 11");
        check("bp_cnt0_2", cnt0, 2);
        I = 32'h12;
        #1 check("bp_full_ready", i_ready, 0);
        s = 1'b1; I = 32'h33;
        #1 check("bp_other_ready", i_ready, 1);
        tick(); $display("push s=1 33");
        check("bp_cnt1", cnt1, 1);
        check("bp_o1", o1, 32'h33);
        s = 1'b0; I = 32'h12;
        tick();
        check("bp_hold_cnt0", cnt0, 2);
        check("bp_head10", o0, 32'h10);
        o0_ready = 1'b1; o1_ready = 1'b1;
        #1 check("bp_no_passthru", i_ready, 0);
        tick(); $display("pop o0 10");
        check("bp_cnt0_after_pop", cnt0, 1);
        check("bp_head11", o0, 32'h11);
        check("bp_cnt1_drained", cnt1, 0);
        check("bp_ready_rises", i_ready, 1);
        tick(); $display("pop o0 11, push s=0 12");
        check("bp_cnt0_pushpop", cnt0, 1);
        check("bp_head12", o0, 32'h12);
        i_valid = 1'b0;
        tick(); $display("pop o0 12");
        check("bp_cnt0_empty", cnt0, 0);
        check("bp_o0_valid_empty", o0_valid, 0);

        // 4. Simultaneous push/pop with pointer wrap
        o0_ready = 1'b0;
        i_valid = 1'b1; s = 1'b0; I = 32'h20;
        tick();
        check("wr_cnt0_start", cnt0, 1);
        o0_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            I = 32'h20 + k;
            check("wr_valid", o0_valid, 1);
            check("wr_head", o0, 32'h20 + k - 1);
            tick();
            $display("push/pop s=0 in=%0h out=%0h", 32'h20 + k, 32'h20 + k - 1);
            check("wr_cnt0", cnt0, 1);
        end
        i_valid = 1'b0;
        check("wr_last", o0, 32'h27);
        tick();
        check("wr_drained", cnt0, 0);

        // 5. Reset mid-operation
        o0_ready = 1'b0; o1_ready = 1'b0;
        i_valid = 1'b1;
        s = 1'b0; I = 32'h40; tick();
        s = 1'b0; I = 32'h41; tick();
        s = 1'b1; I = 32'h50; tick();
        s = 1'b1; I = 32'h51; tick();
        check("mr_cnt0_full", cnt0, 2);
        check("mr_cnt1_full", cnt1, 2);
        rst = 1'b1; s = 1'b0; I = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; i_valid = 1'b0;
        check("mr_cnt0", cnt0, 0);
        check("mr_cnt1", cnt1, 0);
        check("mr_o0_valid", o0_valid, 0);
        check("mr_o1_valid", o1_valid, 0);
        check("mr_o0", o0, 0);
        o0_ready = 1'b1; o1_ready = 1'b1;
        tick();
        check("mr_no_ghost", o0_valid, 0);
        $display("mid-operation reset done");

        // 6. Randomized cross-check against queue scoreboards
        for (int c = 0; c < 1000; c++) begin
            logic exp_ready, exp_v0, exp_v1, push, pop0, pop1;
            i_valid  = 1'($urandom_range(0, 1));
            s        = 1'($urandom_range(0, 1));
            I        = $urandom;
            o0_ready = 1'($urandom_range(0, 1));
            o1_ready = 1'($urandom_range(0, 1));
            #1;
            exp_ready = s ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
            exp_v0    = (q0.size() != 0);
            exp_v1    = (q1.size() != 0);
            check("rnd_i_ready", i_ready, exp_ready);
            check("rnd_o0_valid", o0_valid, exp_v0);
            check("rnd_o1_valid", o1_valid, exp_v1);
            if (exp_v0) check("rnd_o0", o0, q0[0]);
            if (exp_v1) check("rnd_o1", o1, q1[0]);
            push = i_valid & exp_ready;
            pop0 = exp_v0 & o0_ready;
            pop1 = exp_v1 & o1_ready;
            if (pop0) begin
                $display("rnd pop o0 %h", q0[0]);
                void'(q0.pop_front());
            end
            if (pop1) begin
                $display("rnd pop o1 %h", q1[0]);
                void'(q1.pop_front());
            end
            if (push) begin
                $display("rnd push s=%0d %h", s, I);
                if (s) q1.push_back(I);
                else   q0.push_back(I);
            end
            tick();
            check("rnd_cnt0", cnt0, q0.size());
            check("rnd_cnt1", cnt1, q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
